if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Fetch stage directly upstream of the next-PC logic. Owns the architectural PC register.
- Issues one instruction-memory request at a time over a req/gnt + rvalid handshake, then presents {pc, inst} to decode/NPC.
- Loads the NPC result into the PC when the core consumes the current instruction.
- Stalls on memory wait states; flags a misaligned next-PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ALIGN_CHECK, 1, 1 = trap on npc_i[1:0] != 0; 0 = force npc_i[1:0] to 2'b00.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- npc_i  input  32  next PC from NPC block; sampled only on consume
- inst_ready  input  1  core consumes current instruction this cycle (retire)
- inst_valid  output  1  pc_o/inst_o hold a fetched instruction
- pc_o  output  32  PC of the presented instruction (feeds NPC pc)
- inst_o  output  32  fetched instruction word
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address (= PC)
- imem_gnt  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- misalign_err  output  1  sticky: misaligned npc_i was consumed
- fetch_cnt  output  32  completed fetches (optional feature)
- stall_cnt  output  32  cycles in WAIT (optional feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=BOOT, pc=RESET_PC, inst_o=0, inst_valid=0, imem_req=0, misalign_err=0, counters=0.
- States:
  - BOOT: one cycle, then REQ.
  - REQ: imem_req=1, imem_addr=pc. Stays in REQ while gnt=0. On gnt=1, goes to WAIT.
  - WAIT: imem_req=0. On rvalid=1, inst_o<=imem_rdata and goes to HOLD.
  - HOLD: inst_valid=1. On inst_ready=1:
    - aligned npc_i: pc<=npc_i, inst_valid drops next cycle, goes to REQ.
    - misaligned npc_i with ALIGN_CHECK=1: misalign_err<=1, goes to HALT, pc is not updated.
  - HALT: terminal until rst; all outputs are frozen, imem_req=0, inst_valid=0.
- Request stability: while in REQ with gnt=0, imem_req and imem_addr stay constant.
- Single outstanding request. imem_rvalid is ignored in every state except WAIT.
- Same-cycle response: gnt and rvalid in the same cycle are not supported. rvalid is honoured no earlier than the cycle after gnt.
- Outputs pc_o and imem_addr are both driven from the pc register. inst_o is registered.
- Minimum loop: 3 cycles per instruction (REQ → WAIT → HOLD) with gnt and rvalid at the earliest allowed cycles and inst_ready=1 in HOLD.
- inst_ready is ignored outside HOLD.
- rst in any state (including WAIT with a response pending): goes to BOOT next cycle. A late rvalid after reset is dropped because the state is not WAIT.
- ALIGN_CHECK=0: pc<=npc_i & ~32'h3, and misalign_err stays 0.
- PC wrap: 32'hFFFF_FFFC → 32'h0 via npc_i is legal and needs no special handling.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on every WAIT→HOLD transition.
  - stall_cnt increments on every cycle in WAIT with rvalid=0, and every cycle in REQ with gnt=0.
  - Both are 32-bit, wrap at 2^32, cleared by rst, and frozen in HALT.
- Not defined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Reset then gnt and rvalid one cycle apart, rdata=32'h0000_0013, inst_ready=1, npc_i=pc+4:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - inst_valid pulses every 3 cycles.
  - fetch_cnt=3 after three fetches.
- gnt held low for 4 cycles in REQ:
  - imem_req=1 and imem_addr=0x0 stable throughout.
  - stall_cnt=4.
  - WAIT is entered only on gnt.
- HOLD with inst_ready=0 for 5 cycles, then npc_i=32'h0000_0100 with inst_ready=1:
  - inst_valid=1 for 6 cycles.
  - next imem_addr=0x100.
- npc_i=32'h0000_0102 consumed, ALIGN_CHECK=1:
  - misalign_err=1.
  - imem_req stays 0 forever and pc_o stays at the old value.
  - After rst: pc_o=RESET_PC and misalign_err=0.
- rst asserted in WAIT, rvalid arrives the cycle after rst deasserts:
  - inst_valid stays 0.
  - The BOOT→REQ fetch is re-issued at RESET_PC.
- npc_i=32'hFFFF_FFFC, then npc_i=32'h0:
  - imem_addr=0xFFFF_FFFC followed by 0x0, with no error.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one imem request at a time and
// presents {pc, inst} to decode. Optional perf counters behind IF_PERF_CNT_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_BOOT  | one cycle after reset before the first request
//  S_REQ   | imem_req high at imem_addr = pc, waiting for gnt
//  S_WAIT  | request accepted, waiting for rvalid
//  S_HOLD  | instruction presented, waiting for inst_ready
//  S_HALT  | misaligned next-PC consumed, frozen until rst
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_i,
   input  logic        inst_ready,
   output logic        inst_valid,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        misalign_err,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        npc_misaligned;

   assign pc_o           = pc;
   assign imem_addr      = pc;
   assign npc_misaligned = ALIGN_CHECK && (npc_i[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_BOOT;
         pc           <= RESET_PC;
         inst_o       <= 32'h0;
         inst_valid   <= 1'b0;
         imem_req     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            S_BOOT: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state    <= S_WAIT;
                  imem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state      <= S_HOLD;
                  inst_o     <= imem_rdata;
                  inst_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  inst_valid <= 1'b0;
                  if (npc_misaligned) begin
                     // pc keeps the faulting instruction's address for debug
                     state        <= S_HALT;
                     misalign_err <= 1'b1;
                  end else begin
                     state    <= S_REQ;
                     pc       <= npc_i & ~32'h3;
                     imem_req <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state      <= S_BOOT;
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_q <= 32'h0;
         stall_q <= 32'h0;
      end else begin
         if (state == S_WAIT && imem_rvalid)
            fetch_q <= fetch_q + 32'h1;
         if ((state == S_WAIT && !imem_rvalid) || (state == S_REQ && !imem_gnt))
            stall_q <= stall_q + 32'h1;
      end
   end

   assign fetch_cnt = fetch_q;
   assign stall_cnt = stall_q;
`else
   assign fetch_cnt = 32'h0;
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] npc_i;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        misalign_err;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl #(.RESET_PC(RST_PC), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst), .npc_i(npc_i), .inst_ready(inst_ready),
      .inst_valid(inst_valid), .pc_o(pc_o), .inst_o(inst_o),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: which part of the fetch transaction is outstanding
   bit          model_on = 0;
   bit          m_boot, m_asking, m_awaiting, m_presenting, m_halted, m_err;
   logic [31:0] m_pc, m_inst, m_fetches, m_stalls;

   always @(posedge clk) begin
      if (rst) begin
         model_on = 1;
         m_boot = 1; m_asking = 0; m_awaiting = 0; m_presenting = 0;
         m_halted = 0; m_err = 0;
         m_pc = RST_PC; m_inst = 0; m_fetches = 0; m_stalls = 0;
      end else if (model_on && !m_halted) begin
         if (m_boot) begin
            m_boot = 0; m_asking = 1;
         end else if (m_asking) begin
            if (imem_gnt) begin m_asking = 0; m_awaiting = 1; end
            else m_stalls = m_stalls + 1;
         end else if (m_awaiting) begin
            if (imem_rvalid) begin
               m_awaiting = 0; m_presenting = 1; m_inst = imem_rdata;
               m_fetches = m_fetches + 1;
            end else m_stalls = m_stalls + 1;
         end else if (m_presenting && inst_ready) begin
            m_presenting = 0;
            if (npc_i % 4 != 0) begin
               m_halted = 1; m_err = 1;
            end else begin
               m_pc = npc_i; m_asking = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_presenting});
         chk("imem_req", {31'h0, imem_req}, {31'h0, m_asking});
         chk("pc_o", pc_o, m_pc);
         chk("imem_addr", imem_addr, m_pc);
         chk("inst_o", inst_o, m_inst);
         chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
`ifdef IF_PERF_CNT_EN
         chk("fetch_cnt", fetch_cnt, m_fetches);
         chk("stall_cnt", stall_cnt, m_stalls);
`else
         chk("fetch_cnt", fetch_cnt, 32'h0);
         chk("stall_cnt", stall_cnt, 32'h0);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From REQ at the current pc: gnt, then rvalid, then consume with npc
   task automatic fetch(input logic [31:0] npc, input logic [31:0] data);
      imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = data; step();
      imem_rvalid = 0; inst_ready = 1; npc_i = npc; step();
      inst_ready = 0;
   endtask

   int vcount;
   int halt_age;
   int r;

   initial begin
      rst = 1; npc_i = 0; inst_ready = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      step();
      chk("rst_pc", pc_o, RST_PC);
      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_err", {31'h0, misalign_err}, 32'h0);
      rst = 0; step();

      // three back-to-back fetches at the minimum loop rate
      for (int k = 0; k < 3; k++) begin
         chk("seq_addr", imem_addr, k * 4);
         chk("seq_req", {31'h0, imem_req}, 32'h1);
         chk("seq_valid_req", {31'h0, inst_valid}, 32'h0);
         imem_gnt = 1; step();
         chk("seq_valid_wait", {31'h0, inst_valid}, 32'h0);
         imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013; step();
         chk("seq_valid_hold", {31'h0, inst_valid}, 32'h1);
         chk("seq_inst", inst_o, 32'h0000_0013);
         imem_rvalid = 0; inst_ready = 1; npc_i = pc_o + 4; step();
      end
      inst_ready = 0;
      chk("seq_addr3", imem_addr, 32'hC);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt3", fetch_cnt, 32'd3);
      chk("stall_cnt0", stall_cnt, 32'd0);
`else
      chk("fetch_cnt3", fetch_cnt, 32'd0);
`endif

      // gnt held low for four cycles
      imem_rvalid = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stall_req", {31'h0, imem_req}, 32'h1);
         chk("stall_addr", imem_addr, 32'hC);
         chk("stall_valid", {31'h0, inst_valid}, 32'h0);
      end
      imem_rvalid = 0;
`ifdef IF_PERF_CNT_EN
      chk("stall_cnt4", stall_cnt, 32'd4);
`else
      chk("stall_cnt4", stall_cnt, 32'd0);
`endif
      imem_gnt = 1; step();
      chk("gnt_to_wait", {31'h0, imem_req}, 32'h0);
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA5A5_0001; step();
      imem_rvalid = 0;

      // HOLD with inst_ready low for five cycles, then consume npc=0x100
      vcount = 0;
      inst_ready = 0; npc_i = 32'h0000_0200;
      for (int k = 0; k < 5; k++) begin
         if (inst_valid) vcount++;
         step();
      end
      inst_ready = 1; npc_i = 32'h0000_0100;
      if (inst_valid) vcount++;
      step();
      inst_ready = 0;
      chk("hold_cycles", vcount, 6);
      chk("hold_next_addr", imem_addr, 32'h0000_0100);
      chk("hold_next_req", {31'h0, imem_req}, 32'h1);

      // PC wrap through the top of the address space
      fetch(32'hFFFF_FFFC, 32'h1);
      chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      fetch(32'h0, 32'h2);
      chk("wrap_addr_zero", imem_addr, 32'h0);
      chk("wrap_err", {31'h0, misalign_err}, 32'h0);
      fetch(32'h40, 32'h3);
      chk("pre_rst_addr", imem_addr, 32'h40);

      // reset while a response is pending; late rvalid must be dropped
      imem_gnt = 1; step();
      imem_gnt = 0; rst = 1; step();
      rst = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
      imem_rvalid = 0;
      chk("late_rv_valid", {31'h0, inst_valid}, 32'h0);
      chk("late_rv_req", {31'h0, imem_req}, 32'h1);
      chk("late_rv_addr", imem_addr, RST_PC);
      step();
      chk("late_rv_valid2", {31'h0, inst_valid}, 32'h0);

      // misaligned npc halts with the old pc
      fetch(32'h8, 32'h4);
      fetch(32'h0000_0102, 32'h5);
      chk("mis_err", {31'h0, misalign_err}, 32'h1);
      chk("mis_pc", pc_o, 32'h8);
      for (int k = 0; k < 10; k++) begin
         imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom); inst_ready = 1'($urandom);
         npc_i = $urandom; step();
         chk("halt_req", {31'h0, imem_req}, 32'h0);
         chk("halt_valid", {31'h0, inst_valid}, 32'h0);
         chk("halt_pc", pc_o, 32'h8);
      end
      rst = 1; step();
      rst = 0;
      chk("halt_rst_pc", pc_o, RST_PC);
      chk("halt_rst_err", {31'h0, misalign_err}, 32'h0);

      // randomized traffic against the model
      halt_age = 0;
      for (int n = 0; n < 4000; n++) begin
         halt_age = m_halted ? halt_age + 1 : 0;
         rst = ($urandom_range(0, 199) == 0) || (halt_age > 6 && $urandom_range(0, 3) == 0);
         imem_gnt = ($urandom_range(0, 2) == 0);
         imem_rvalid = ($urandom_range(0, 2) == 0);
         imem_rdata = $urandom;
         inst_ready = 1'($urandom);
         r = $urandom_range(0, 31);
         if (r == 0) npc_i = $urandom;
         else if (r == 1) npc_i = $urandom & 32'hFFFF_FFFC;
         else if (r == 2) npc_i = 32'hFFFF_FFFC;
         else npc_i = m_pc + 4;
         step();
      end
      rst = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
